pb_conditioner: RTL and testbench
=================================

Name: pb_conditioner

Overview:
- Per-button input conditioner directly upstream of the RPN calculator core; one instance each for the Enter and Undo pushbuttons.
- Chain: raw asynchronous pushbutton → 2-FF synchronizer → counter-based debouncer FSM → single-cycle press, release and long-press pulses plus a clean level.
- The calculator core consumes o_press as its one-cycle Enter/Undo strobe.

Parameters:
- N_debouncer, 10: width of the stability counter; input must be stable 2**N_debouncer consecutive synchronized cycles to be accepted.
- N_long, 24: width of the hold counter; o_long fires after 2**N_long cycles in PRESSED.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_resetN  input  1  reset; asynchronous, active-low.
- i_PB  input  1  raw pushbutton, asynchronous to i_clk, active-high.
- o_level  output  1  debounced button level.
- o_press  output  1  one-cycle pulse on accepted press.
- o_release  output  1  one-cycle pulse on accepted release.
- o_long  output  1  one-cycle pulse, at most once per press, on long hold.

Behaviour:
- Reset, asynchronous (i_resetN=0):
  - Sync FFs, counters and all outputs go to 0; state goes to IDLE.
  - Reset applies immediately mid-count, mid-pulse and mid-hold.
- Synchronizer: s = i_PB delayed by two flops, both reset to 0. The FSM only sees s.
- LIMIT = 2**N_debouncer - 1; counter cnt is N_debouncer bits wide.
- FSM states and transitions:
  - IDLE: if s=1 → ARM_PRESS, cnt←0; else stay.
  - ARM_PRESS: if s=0 → IDLE, cnt←0. Else if cnt==LIMIT → PRESSED, assert o_press next cycle. Else cnt←cnt+1.
  - PRESSED: hold counter hcnt runs (N_long bits, saturating; cleared on entry). When hcnt reaches 2**N_long-1, o_long pulses once; no further o_long until the next press. If s=0 → ARM_RELEASE, cnt←0.
  - ARM_RELEASE: if s=1 → PRESSED; hcnt and the o_long-done flag are NOT cleared. Else if cnt==LIMIT → IDLE, assert o_release. Else cnt←cnt+1.
- Outputs (all registered):
  - o_level=1 exactly while state is PRESSED or ARM_RELEASE, starting the same cycle o_press is high.
  - o_press, o_release and o_long are each high for exactly one cycle. They never overlap, and never all fire in the same cycle.
- Latency:
  - With i_PB first sampled 1 at rising edge 1 and held, o_press is high during the cycle after edge 2**N_debouncer+3.
  - Release is symmetric: o_release is high after edge 2**N_debouncer+3 counted from the first edge sampling i_PB=0.
- Glitches:
  - Any s pulse shorter than 2**N_debouncer cycles in IDLE or PRESSED produces no output change.
  - cnt restarts from 0 on every re-arm.
- Button already held when i_resetN deasserts: a normal press sequence runs, and o_press fires at the standard latency.
- The counter never wraps: transitions occur at LIMIT, so cnt never exceeds LIMIT.

Test Plan:
- Clean press (N_debouncer=2): reset, then i_PB=1 from edge 1 held 20 cycles → o_press high exactly one cycle after edge 7, o_level=1 from that cycle, o_release=0.
- Bounce (N_debouncer=2): i_PB toggles 1,0,1,0,1 on consecutive edges, then held 1 → no pulse during bouncing; single o_press 7 edges after the final rising sample; exactly one o_press total.
- Release (N_debouncer=2): from PRESSED, i_PB=0 from edge k, held → o_release one cycle after edge k+6, o_level→0 that same cycle; a 2-cycle low glitch instead keeps o_level=1 with no o_release.
- Long press (N_debouncer=2, N_long=4): hold i_PB 60 cycles → one o_press, then exactly one o_long 15 cycles into PRESSED, no second o_long; a 2-cycle low glitch mid-hold causes no extra o_long.
- Reset mid-operation: assert i_resetN=0 asynchronously between edges while in ARM_PRESS and again while o_press is high → all outputs 0 immediately; after release with i_PB held, o_press fires 7 edges later (N_debouncer=2).
- Default parameters (N_debouncer=10): held press → o_press after edge 1027; pulse widths checked equal to 1 cycle in all cases.

Source files
------------

// File: rtl/pb_conditioner.sv
// rtl/pb_conditioner.sv - pushbutton synchronizer, debouncer and press/release/long-press pulse generator
module pb_conditioner #(
    parameter int N_debouncer = 10,
    parameter int N_long      = 24
) (
    input  logic i_clk,
    input  logic i_resetN,
    input  logic i_PB,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } state_t;

    localparam logic [N_debouncer-1:0] LIMIT = '1;
    localparam logic [N_long-1:0]      HMAX  = '1;
    localparam logic [N_long-1:0]      HPRE  = HMAX - 1'b1;

    state_t                 state, state_n;
    logic [N_debouncer-1:0] cnt, cnt_n;
    logic [N_long-1:0]      hcnt, hcnt_n;
    logic                   long_done, long_done_n;
    logic                   pb_meta, s;
    logic                   level_n, press_n, release_n, long_n;

    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            pb_meta <= 1'b0;
            s       <= 1'b0;
        end else begin
            pb_meta <= i_PB;
            s       <= pb_meta;
        end
    end

    // State, counters and the registered outputs all update together
    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            long_done <= 1'b0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            hcnt      <= hcnt_n;
            long_done <= long_done_n;
            o_level   <= level_n;
            o_press   <= press_n;
            o_release <= release_n;
            o_long    <= long_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hcnt_n      = hcnt;
        long_done_n = long_done;
        case (state)
            IDLE: begin
                if (s) begin
                    state_n = ARM_PRESS;
                    cnt_n   = '0;
                end
            end
            ARM_PRESS: begin
                if (!s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == LIMIT) begin
                    state_n     = PRESSED;
                    hcnt_n      = '0;
                    long_done_n = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_n = ARM_RELEASE;
                    cnt_n   = '0;
                end else begin
                    if (hcnt != HMAX)
                        hcnt_n = hcnt + 1'b1;
                    if (hcnt == HPRE && !long_done)
                        long_done_n = 1'b1;
                end
            end
            ARM_RELEASE: begin
                // A bounce back to 1 resumes the hold without restarting it
                if (s) begin
                    state_n = PRESSED;
                end else if (cnt == LIMIT) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        level_n   = (state_n == PRESSED) || (state_n == ARM_RELEASE);
        press_n   = (state == ARM_PRESS) && s && (cnt == LIMIT);
        release_n = (state == ARM_RELEASE) && !s && (cnt == LIMIT);
        long_n    = (state == PRESSED) && s && (hcnt == HPRE) && !long_done;
    end

endmodule

// File: tb/tb_pb_conditioner.sv
// tb/tb_pb_conditioner.sv - directed self-checking bench for pb_conditioner
module tb_pb_conditioner;

    logic clk = 1'b0;
    logic rst_n;
    logic pb_a, pb_b;
    logic a_level, a_press, a_release, a_long;
    logic b_level, b_press, b_release, b_long;

    int errors = 0;
    int checks = 0;
    int ecnt;
    int np, pe, nr, re, nl, le, ovl, lrise, lfall;
    int npb, peb, nrb, reb, lrise_b;
    logic lvl_prev, lvl_prev_b;

    pb_conditioner #(.N_debouncer(2), .N_long(4)) dut_a (
        .i_clk     (clk),
        .i_resetN  (rst_n),
        .i_PB      (pb_a),
        .o_level   (a_level),
        .o_press   (a_press),
        .o_release (a_release),
        .o_long    (a_long)
    );

    pb_conditioner dut_b (
        .i_clk     (clk),
        .i_resetN  (rst_n),
        .i_PB      (pb_b),
        .o_level   (b_level),
        .o_press   (b_press),
        .o_release (b_release),
        .o_long    (b_long)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic clr();
        np = 0; pe = -1; nr = 0; re = -1; nl = 0; le = -1; ovl = 0;
        lrise = -1; lfall = -1;
        npb = 0; peb = -1; nrb = 0; reb = -1; lrise_b = -1;
    endtask

    // One rising edge; outputs are observed 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
        if (a_press)   begin np++; pe = ecnt; end
        if (a_release) begin nr++; re = ecnt; end
        if (a_long)    begin nl++; le = ecnt; end
        if ((a_press && a_release) || (a_press && a_long) || (a_release && a_long)) ovl++;
        if (a_level && !lvl_prev) lrise = ecnt;
        if (!a_level && lvl_prev) lfall = ecnt;
        lvl_prev = a_level;
        if (b_press)   begin npb++; peb = ecnt; end
        if (b_release) begin nrb++; reb = ecnt; end
        if (b_level && !lvl_prev_b) lrise_b = ecnt;
        lvl_prev_b = b_level;
    endtask

    task automatic run(input int n, input logic va, input logic vb);
        pb_a = va;
        pb_b = vb;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rel_reset();
        pb_a = 1'b0;
        pb_b = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ecnt = 0;
        lvl_prev = 1'b0;
        lvl_prev_b = 1'b0;
        clr();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"},   a_level,   1'b0);
        chk({tag, "_press"},   a_press,   1'b0);
        chk({tag, "_release"}, a_release, 1'b0);
        chk({tag, "_long"},    a_long,    1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        pb_a = 1'b1;
        pb_b = 1'b1;
        #23;
        chk_all_zero("rst");
        chk("rst_b_level", b_level, 1'b0);
        chk("rst_b_press", b_press, 1'b0);

        // Clean press, N_debouncer=2
        rel_reset();
        run(12, 1'b1, 1'b0);
        chk("clean_npress", np, 1);
        chk("clean_press_edge", pe, 7);
        chk("clean_level_rise", lrise, 7);
        chk("clean_nrelease", nr, 0);
        chk("clean_nlong", nl, 0);

        // 2-cycle low glitch while pressed
        clr();
        run(2, 1'b0, 1'b0);
        run(4, 1'b1, 1'b0);
        chk("glitch_level_fall", lfall, -1);
        chk("glitch_level", a_level, 1'b1);
        chk("glitch_nrelease", nr, 0);
        chk("glitch_npress", np, 0);

        // Release starting at edge 19
        clr();
        run(12, 1'b0, 1'b0);
        chk("rel_nrelease", nr, 1);
        chk("rel_edge", re, 25);
        chk("rel_level_fall", lfall, 25);
        chk("rel_npress", np, 0);
        chk("rel_nlong", nl, 0);

        // Bounce 1,0,1,0,1 then held
        rst_n = 1'b0;
        rel_reset();
        run(1, 1'b1, 1'b0);
        run(1, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0);
        run(1, 1'b0, 1'b0);
        run(16, 1'b1, 1'b0);
        chk("bounce_npress", np, 1);
        chk("bounce_press_edge", pe, 11);
        chk("bounce_nrelease", nr, 0);

        // Long press with a glitch after o_long
        rst_n = 1'b0;
        rel_reset();
        run(39, 1'b1, 1'b0);
        run(2, 1'b0, 1'b0);
        run(19, 1'b1, 1'b0);
        chk("long_npress", np, 1);
        chk("long_press_edge", pe, 7);
        chk("long_nlong", nl, 1);
        chk("long_edge", le, 22);
        chk("long_nrelease", nr, 0);
        chk("long_overlap", ovl, 0);
        chk("long_level_fall", lfall, -1);

        // Asynchronous reset mid-hold
        #3 rst_n = 1'b0;
        #1 chk_all_zero("rst_hold");

        // Reset while arming, then while o_press is high
        rel_reset();
        run(4, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_arm");
        rel_reset();
        run(7, 1'b1, 1'b0);
        chk("pulse_press_high", a_press, 1'b1);
        chk("pulse_level_high", a_level, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_pulse");
        rel_reset();
        run(12, 1'b1, 1'b0);
        chk("after_rst_npress", np, 1);
        chk("after_rst_press_edge", pe, 7);

        // Default parameters: 1024-cycle stability window
        rst_n = 1'b0;
        rel_reset();
        run(1040, 1'b0, 1'b1);
        chk("dflt_npress", npb, 1);
        chk("dflt_press_edge", peb, 1027);
        chk("dflt_level_rise", lrise_b, 1027);
        chk("dflt_nrelease", nrb, 0);
        chk("dflt_long", b_long, 1'b0);
        run(1040, 1'b0, 1'b0);
        chk("dflt_nrelease2", nrb, 1);
        chk("dflt_release_edge", reb, 2067);
        chk("dflt_level_end", b_level, 1'b0);
        chk("dflt_a_quiet", np, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
